// File: rtl/fft_rd_if.sv
// Read-side bundle between the FFT read sequencer and the butterfly feed stage.
// master = sequencer (drives addresses/status), slave = consumer/bench (drives start/hold/wb_done).
interface fft_rd_if #(
    parameter int ADDR_WIDTH  = 9,
    parameter int STAGE_WIDTH = 4
);
    logic                   start;
    logic                   hold;
    logic                   wb_done;
    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic                   rd_valid;
    logic                   first_level;
    logic [STAGE_WIDTH-1:0] stage;
    logic [ADDR_WIDTH-1:0]  tw_addr;
    logic                   busy;
    logic                   done;

    modport master (
        input  start, hold, wb_done,
        output rd_addr, rd_valid, first_level, stage, tw_addr, busy, done
    );

    modport slave (
        output start, hold, wb_done,
        input  rd_addr, rd_valid, first_level, stage, tw_addr, busy, done
    );
endinterface

// File: rtl/fft_rd_ctrl.sv
// Per-stage paired-bank read sequencer for the in-place radix-2 FFT core.
// Latency: one cycle from an accepted READ cycle to the registered rd_addr/rd_valid.
// Backpressure: hold freezes the read counter and drops rd_valid; ignored outside READ.
module fft_rd_ctrl #(
    parameter int LOG2_N      = 10,
    parameter int ADDR_WIDTH  = 9,
    parameter int STAGE_WIDTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    fft_rd_if.master  rd
);

    typedef enum logic [1:0] {IDLE, READ, WAIT_WB, FINISH} state_t;

    localparam logic [STAGE_WIDTH-1:0] LAST_STAGE = STAGE_WIDTH'(LOG2_N - 1);

    state_t                 state;
    state_t                 nxt_state;
    logic [ADDR_WIDTH-1:0]  cnt;
    logic [ADDR_WIDTH-1:0]  nxt_cnt;
    logic [ADDR_WIDTH-1:0]  nxt_rd_addr;
    logic [ADDR_WIDTH-1:0]  nxt_tw_addr;
    logic [STAGE_WIDTH-1:0] nxt_stage;
    logic                   nxt_rd_valid;
    logic                   nxt_busy;
    logic                   nxt_done;
    logic                   nxt_first;
    logic                   last_cnt;
    logic [31:0]            rot_amt;

    // Rotation is done on a doubled copy so the bits shifted out re-enter at the bottom.
    function automatic logic [ADDR_WIDTH-1:0] rotl(input logic [ADDR_WIDTH-1:0] v,
                                                   input logic [31:0] r);
        logic [2*ADDR_WIDTH-1:0] d;
        d = {v, v} << r;
        return d[2*ADDR_WIDTH-1:ADDR_WIDTH];
    endfunction

    assign last_cnt = &cnt;
    assign rot_amt  = 32'(rd.stage) % 32'(ADDR_WIDTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    if (rd.start) nxt_state = READ;
            READ:    if (!rd.hold && last_cnt) nxt_state = WAIT_WB;
            WAIT_WB: if (rd.wb_done) nxt_state = (rd.stage == LAST_STAGE) ? FINISH : READ;
            FINISH:  nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        nxt_cnt      = cnt;
        nxt_stage    = rd.stage;
        nxt_rd_addr  = rd.rd_addr;
        nxt_tw_addr  = rd.tw_addr;
        nxt_rd_valid = 1'b0;
        nxt_busy     = rd.busy;
        nxt_done     = 1'b0;
        case (state)
            IDLE: begin
                if (rd.start) begin
                    nxt_stage = '0;
                    nxt_cnt   = '0;
                    nxt_busy  = 1'b1;
                end
            end
            READ: begin
                if (!rd.hold) begin
                    nxt_rd_valid = 1'b1;
                    nxt_rd_addr  = rotl(cnt, rot_amt);
                    nxt_tw_addr  = cnt << rd.stage;
                    nxt_cnt      = cnt + ADDR_WIDTH'(1);
                end
            end
            WAIT_WB: begin
                if (rd.wb_done && rd.stage != LAST_STAGE) begin
                    nxt_stage = rd.stage + STAGE_WIDTH'(1);
                    nxt_cnt   = '0;
                end
            end
            FINISH: begin
                nxt_done  = 1'b1;
                nxt_busy  = 1'b0;
                nxt_stage = '0;
            end
            default: ;
        endcase
        nxt_first = nxt_busy && (nxt_stage == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            rd.stage       <= '0;
            rd.rd_addr     <= '0;
            rd.tw_addr     <= '0;
            rd.rd_valid    <= 1'b0;
            rd.busy        <= 1'b0;
            rd.done        <= 1'b0;
            rd.first_level <= 1'b0;
        end else begin
            cnt            <= nxt_cnt;
            rd.stage       <= nxt_stage;
            rd.rd_addr     <= nxt_rd_addr;
            rd.tw_addr     <= nxt_tw_addr;
            rd.rd_valid    <= nxt_rd_valid;
            rd.busy        <= nxt_busy;
            rd.done        <= nxt_done;
            rd.first_level <= nxt_first;
        end
    end

endmodule

// File: tb/tb_fft_rd_ctrl.sv
// Directed bench for fft_rd_ctrl: a small (N=8) instance for address/flow checks
// and a default-size (N=1024) instance for the full-transform run.
module tb_fft_rd_ctrl;

    logic clk = 1'b0;
    logic rst_n_s = 1'b1;
    logic rst_n_l = 1'b1;

    always #5 clk = ~clk;

    fft_rd_if #(.ADDR_WIDTH(2), .STAGE_WIDTH(4)) bs ();
    fft_rd_if #(.ADDR_WIDTH(9), .STAGE_WIDTH(4)) bl ();

    fft_rd_ctrl #(.LOG2_N(3), .ADDR_WIDTH(2), .STAGE_WIDTH(4)) u_small (
        .clk   (clk),
        .rst_n (rst_n_s),
        .rd    (bs)
    );

    fft_rd_ctrl #(.LOG2_N(10), .ADDR_WIDTH(9), .STAGE_WIDTH(4)) u_large (
        .clk   (clk),
        .rst_n (rst_n_l),
        .rd    (bl)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] rd_q[$];
    logic [31:0] tw_q[$];
    logic [31:0] fl_q[$];
    logic [31:0] st_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic collect(input int n, input int budget);
        rd_q.delete(); tw_q.delete(); fl_q.delete(); st_q.delete();
        for (int i = 0; i < budget; i++) begin
            if (rd_q.size() >= n) break;
            tick();
            if (bs.rd_valid) begin
                rd_q.push_back(32'(bs.rd_addr));
                tw_q.push_back(32'(bs.tw_addr));
                fl_q.push_back(32'(bs.first_level));
                st_q.push_back(32'(bs.stage));
            end
        end
    endtask

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD;
    endfunction

    // ea/et hold four 2-bit expected values, element i at bits [2i+1:2i]
    task automatic check_stage(input string tag, input int stg, input logic [7:0] ea,
                               input logic [7:0] et, input logic efl);
        collect(4, 40);
        chk({tag, "_nrd"}, 32'(rd_q.size()), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), q_at(rd_q, i), 32'(ea[2*i +: 2]));
            chk($sformatf("%s_tw%0d", tag, i),   q_at(tw_q, i), 32'(et[2*i +: 2]));
            chk($sformatf("%s_fl%0d", tag, i),   q_at(fl_q, i), 32'(efl));
            chk($sformatf("%s_st%0d", tag, i),   q_at(st_q, i), 32'(stg));
        end
    endtask

    task automatic drain(input string tag);
        int extra;
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bs.rd_valid) extra++;
        end
        chk({tag, "_extra_rd"}, 32'(extra), 0);
    endtask

    task automatic wb_pulse();
        bs.wb_done = 1'b1;
        tick();
        bs.wb_done = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"},  32'(bs.rd_addr), 0);
        chk({tag, "_vld"},   32'(bs.rd_valid), 0);
        chk({tag, "_fl"},    32'(bs.first_level), 0);
        chk({tag, "_stage"}, 32'(bs.stage), 0);
        chk({tag, "_tw"},    32'(bs.tw_addr), 0);
        chk({tag, "_busy"},  32'(bs.busy), 0);
        chk({tag, "_done"},  32'(bs.done), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_l[16];
        int done_cnt;
        int max_stage;
        int tail;

        bs.start = 1'b0; bs.hold = 1'b0; bs.wb_done = 1'b0;
        bl.start = 1'b0; bl.hold = 1'b0; bl.wb_done = 1'b0;
        #2;
        rst_n_s = 1'b0;
        rst_n_l = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst");
        chk("rst_l_busy", 32'(bl.busy), 0);
        rst_n_s = 1'b1;
        rst_n_l = 1'b1;
        tick();

        // Basic three-stage run
        bs.start = 1'b1; tick(); bs.start = 1'b0;
        chk("start_busy", 32'(bs.busy), 1);
        chk("start_fl", 32'(bs.first_level), 1);
        chk("start_stage", 32'(bs.stage), 0);
        chk("start_vld", 32'(bs.rd_valid), 0);
        check_stage("s0", 0, 8'hE4, 8'hE4, 1'b1);
        drain("s0");
        chk("s0_wait_fl", 32'(bs.first_level), 1);
        wb_pulse();
        chk("s1_stage", 32'(bs.stage), 1);
        chk("s1_fl", 32'(bs.first_level), 0);
        check_stage("s1", 1, 8'hD8, 8'h88, 1'b0);
        drain("s1");
        wb_pulse();
        check_stage("s2", 2, 8'hE4, 8'h00, 1'b0);
        drain("s2");
        chk("s2_busy", 32'(bs.busy), 1);
        wb_pulse();
        chk("fin_done_early", 32'(bs.done), 0);
        chk("fin_busy_early", 32'(bs.busy), 1);
        tick();
        chk("fin_done", 32'(bs.done), 1);
        chk("fin_busy", 32'(bs.busy), 0);
        chk("fin_stage", 32'(bs.stage), 0);
        chk("fin_fl", 32'(bs.first_level), 0);
        tick();
        chk("fin_done_once", 32'(bs.done), 0);

        // Hold during stage 0, then ignored start/wb_done during stage 1
        bs.start = 1'b1; tick(); bs.start = 1'b0;
        collect(2, 20);
        chk("h_pre_n", 32'(rd_q.size()), 2);
        chk("h_pre_addr", 32'(bs.rd_addr), 1);
        bs.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("h_vld%0d", i), 32'(bs.rd_valid), 0);
            chk($sformatf("h_addr%0d", i), 32'(bs.rd_addr), 1);
        end
        bs.hold = 1'b0;
        collect(2, 20);
        chk("h_post_n", 32'(rd_q.size()), 2);
        chk("h_post_a0", q_at(rd_q, 0), 2);
        chk("h_post_a1", q_at(rd_q, 1), 3);
        drain("h");
        wb_pulse();
        chk("ig_stage_entry", 32'(bs.stage), 1);
        collect(2, 20);
        chk("ig_pre_n", 32'(rd_q.size()), 2);
        bs.start = 1'b1; bs.wb_done = 1'b1;
        tick();
        bs.start = 1'b0; bs.wb_done = 1'b0;
        chk("ig_vld", 32'(bs.rd_valid), 1);
        chk("ig_addr", 32'(bs.rd_addr), 1);
        chk("ig_stage", 32'(bs.stage), 1);
        collect(1, 20);
        chk("ig_last_addr", q_at(rd_q, 0), 3);
        drain("ig");
        chk("ig_stage_wait", 32'(bs.stage), 1);
        wb_pulse();
        collect(4, 40);
        chk("ig_s2_n", 32'(rd_q.size()), 4);
        drain("ig_s2");
        wb_pulse();
        tick(); tick();
        chk("ig_idle_busy", 32'(bs.busy), 0);

        // Asynchronous reset in the middle of stage 1 reads
        bs.start = 1'b1; tick(); bs.start = 1'b0;
        collect(4, 40);
        drain("r_s0");
        wb_pulse();
        collect(2, 20);
        chk("r_pre_stage", 32'(bs.stage), 1);
        chk("r_pre_busy", 32'(bs.busy), 1);
        #2;
        rst_n_s = 1'b0;
        #1;
        chk_zero("mid_rst");
        tick(); tick();
        chk("mid_rst_hold_busy", 32'(bs.busy), 0);
        rst_n_s = 1'b1;
        tick();
        bs.start = 1'b1; tick(); bs.start = 1'b0;
        chk("r_new_stage", 32'(bs.stage), 0);
        chk("r_new_fl", 32'(bs.first_level), 1);
        collect(1, 20);
        chk("r_new_addr", q_at(rd_q, 0), 0);
        chk("r_new_rd_stage", q_at(st_q, 0), 0);

        // Default-size full transform with immediate write-back responses
        for (int i = 0; i < 16; i++) cnt_l[i] = 0;
        done_cnt = 0;
        max_stage = 0;
        tail = 0;
        bl.start = 1'b1; tick(); bl.start = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            tick();
            bl.wb_done = 1'b0;
            if (bl.rd_valid) begin
                cnt_l[bl.stage]++;
                if (cnt_l[bl.stage] == 512) bl.wb_done = 1'b1;
            end
            if (int'(bl.stage) > max_stage) max_stage = int'(bl.stage);
            if (bl.done) done_cnt++;
            if (done_cnt > 0) tail++;
            if (tail > 10) break;
        end
        bl.wb_done = 1'b0;
        for (int s = 0; s < 10; s++) chk($sformatf("l_reads_s%0d", s), 32'(cnt_l[s]), 512);
        chk("l_max_stage", 32'(max_stage), 9);
        chk("l_done_cnt", 32'(done_cnt), 1);
        chk("l_end_busy", 32'(bl.busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
